// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide engine feeding the HI/LO register file.
// Multiplies wait out a fixed latency; divides run restoring radix-2 on magnitudes.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             hi_valid,
  output logic [WIDTH-1:0] hi_data,
  output logic             lo_valid,
  output logic [WIDTH-1:0] lo_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
  localparam int PW = 2 * WIDTH + 2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_n;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             accept, commit;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;
  assign accept    = req_valid & req_ready & ~flush;

  // In IDLE the commit can happen on the accept edge, so use live inputs.
  logic [2:0]       opc;
  logic [WIDTH-1:0] opa, opb;
  assign opc = (state == IDLE) ? req_op : op_q;
  assign opa = (state == IDLE) ? req_a  : a_q;
  assign opb = (state == IDLE) ? req_b  : b_q;

  logic is_mul, is_div, is_mt;
  assign is_mul = (opc == OP_MULT) | (opc == OP_MULTU);
  assign is_div = (opc == OP_DIV)  | (opc == OP_DIVU);
  assign is_mt  = (opc == OP_MTHI) | (opc == OP_MTLO);

  function automatic logic [WIDTH-1:0] absv(
    input logic [WIDTH-1:0] x,
    input logic             sg
  );
    return (sg & x[WIDTH-1]) ? -x : x;
  endfunction

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              if (MUL_LAT == 1) begin
                state_n = DONE;
                commit  = 1'b1;
              end else begin
                state_n = MUL;
              end
            end
            is_div: state_n = DIV;
            is_mt: begin
              state_n = DONE;
              commit  = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end
      MUL: begin
        if (flush) begin
          state_n = IDLE;
        end else if (cnt == CW'(MUL_LAT - 2)) begin
          state_n = DONE;
          commit  = 1'b1;
        end
      end
      DIV: begin
        if (flush) begin
          state_n = IDLE;
        end else if (cnt == CW'(WIDTH - 1)) begin
          state_n = DONE;
          commit  = 1'b1;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] rem_n, quo_n;
  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    trial = {1'b0, sh} - {2'b00, dvs};
    if (trial[WIDTH+1]) begin
      rem_n = sh[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

  logic signed [WIDTH:0] ma, mb;
  logic signed [PW-1:0]  prod;
  logic                  sx;
  assign sx   = (opc == OP_MULT);
  assign ma   = {sx & opa[WIDTH-1], opa};
  assign mb   = {sx & opb[WIDTH-1], opb};
  assign prod = PW'(ma) * PW'(mb);

  logic             neg_q, neg_r;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign neg_q = (op_q == OP_DIV) & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign neg_r = (op_q == OP_DIV) & a_q[WIDTH-1];

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (1'b1)
      is_mt: begin
        res_hi = opa;
        res_lo = opa;
      end
      is_mul: begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
      end
      is_div: begin
        if (b_q == '0) begin
          res_hi = a_q;
          res_lo = '1;
        end else begin
          res_hi = neg_r ? -rem_n : rem_n;
          res_lo = neg_q ? -quo_n : quo_n;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      hi_valid <= 1'b0;
      lo_valid <= 1'b0;
      hi_data  <= '0;
      lo_data  <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        cnt  <= '0;
        rem  <= '0;
        quo  <= absv(req_a, req_op == OP_DIV);
        dvs  <= absv(req_b, req_op == OP_DIV);
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + 1'b1;
      end
      if (state == DIV) begin
        rem <= rem_n;
        quo <= quo_n;
      end
      hi_valid <= commit & (opc != OP_MTLO);
      lo_valid <= commit & (opc != OP_MTHI);
      if (commit && opc != OP_MTLO) hi_data <= res_hi;
      if (commit && opc != OP_MTHI) lo_data <= res_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, flush/reset aborts,
// then random traffic checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam int ML = 3;

  logic         clk = 1'b0;
  logic         reset, flush, req_valid, req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         hi_valid, lo_valid, busy;
  logic [W-1:0] hi_data, lo_data;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .hi_valid(hi_valid), .hi_data(hi_data),
    .lo_valid(lo_valid), .lo_data(lo_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       hv;
    logic       lv;
    logic [W-1:0] hd;
    logic [W-1:0] ld;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: what HI/LO should receive, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output exp_t e);
    longint          sa, sb_, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.hv = 1'b1; e.lv = 1'b1; e.hd = '0; e.ld = '0;
    e.at = 0;
    case (op)
      3'd0: begin
        sq = sa * sb_;
        e.hd = sq[63:32]; e.ld = sq[31:0]; e.at = ML;
      end
      3'd1: begin
        up = ua * ub;
        e.hd = up[63:32]; e.ld = up[31:0]; e.at = ML;
      end
      3'd2: begin
        e.at = W + 1;
        if (b == 0) begin
          e.hd = a; e.ld = '1;
        end else begin
          sq = sa / sb_; sr = sa % sb_;
          e.hd = sr[31:0]; e.ld = sq[31:0];
        end
      end
      3'd3: begin
        e.at = W + 1;
        if (b == 0) begin
          e.hd = a; e.ld = '1;
        end else begin
          up = ua / ub; e.ld = up[31:0];
          up = ua % ub; e.hd = up[31:0];
        end
      end
      3'd4: begin e.hd = a; e.lv = 1'b0; e.at = 1; end
      3'd5: begin e.ld = a; e.hv = 1'b0; e.at = 1; end
      default: begin e.hv = 1'b0; e.lv = 1'b0; end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit expect_wr,
                       output int acc);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL accept_timeout op=%0d", op);
    end
    acc = cyc;
    model(op, a, b, e);
    e.at = e.at + acc;
    if (expect_wr && (e.hv || e.lv)) sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && (hi_valid || lo_valid)) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_pulse got hv=%b lv=%b required none (cycle %0d)",
                 hi_valid, lo_valid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.at));
        chk("hi_valid", 64'(hi_valid), 64'(e.hv));
        chk("lo_valid", 64'(lo_valid), 64'(e.lv));
        if (e.hv) chk("hi_data", 64'(hi_data), 64'(e.hd));
        if (e.lv) chk("lo_data", 64'(lo_data), 64'(e.ld));
      end
    end
  end

  logic [W-1:0] corner [6] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h1, 32'h2};

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
    if ($urandom_range(2) == 0) return W'($urandom_range(17));
    return $urandom;
  endfunction

  initial begin
    int acc, acc2;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", 64'({hi_valid, lo_valid}), 64'd0);
    chk("rst_data", {hi_data, lo_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, acc);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
    chk("multu_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("multu_busy_c2", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk("multu_busy_c4", 64'(busy), 64'd0);

    issue(3'd2, -32'sd7, 32'd2, 1'b1, acc);
    issue(3'd3, 32'd7, 32'd0, 1'b1, acc);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    issue(3'd2, 32'd100, 32'd0, 1'b1, acc);

    issue(3'd4, 32'h1234, 32'd0, 1'b1, acc);
    issue(3'd5, 32'h5678, 32'd0, 1'b1, acc2);
    chk("mtlo_b2b_accept", 64'(acc2 - acc), 64'd2);

    // Flushed divide must never write.
    issue(3'd2, 32'd1000, 32'd3, 1'b0, acc);
    wait_until(acc + 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready_c11", 64'(req_ready), 64'd1);
    wait_until(acc + 41);

    // Reset in the middle of a divide.
    issue(3'd3, 32'hDEAD_BEEF, 32'd9, 1'b0, acc);
    wait_until(acc + 20);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_valids", 64'({hi_valid, lo_valid}), 64'd0);
    chk("midrst_data", {hi_data, lo_data}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, acc);

    issue(3'd6, 32'h1, 32'h2, 1'b1, acc);
    issue(3'd7, 32'h3, 32'h4, 1'b1, acc);

    for (int i = 0; i < 50; i++) begin
      issue(3'($urandom_range(7)), rnd_op(), rnd_op(), 1'b1, acc);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (W + 5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
